mem_access_unit: RTL
====================

# mem_access_unit

Memory-access front end placed between the EX/MEM pipeline register and the word-addressed data memory in the 8-stage pipeline. Accepts load/store requests of byte, halfword or word size and applies little-endian lane selection with sign or zero extension on loads. Implements sub-word stores as a two-cycle read-modify-write on the word-only memory, and stalls the pipeline during that window. Flags misaligned and out-of-range accesses instead of issuing them.

## Interface
- `DEPTH_WORDS`, 64, number of 32-bit words in the data memory; word index `req_addr[31:2]` must be `< DEPTH_WORDS`.
- `clk` in 1, single clock; all state updates on the rising edge.
- `reset` in 1, synchronous, active-high.
- `req_valid` in 1, request present from EX/MEM.
- `req_read` in 1, load request.
- `req_write` in 1, store request; takes priority if asserted together with `req_read`.
- `req_size` in 2, 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned` in 1, loads only: 1 zero-extends, 0 sign-extends.
- `req_addr` in 32, byte address.
- `req_wdata` in 32, store data; the sub-word value is in the low bits.
- `req_ready` out 1, request accepted this cycle when `req_valid && req_ready`; pipeline stalls when low.
- `resp_valid` out 1, one-cycle pulse per completed request.
- `resp_rdata` out 32, extended load data; 0 for stores and errors.
- `mem_err` out 1, one-cycle pulse alongside `resp_valid` for a rejected access.
- `dm_MemRead` out 1, `dm_MemWrite` out 1, `dm_addr` out 32, `dm_write_data` out 32: data-memory request outputs.
- `dm_read_data` in 32, combinational read data from the memory.

## Operation
- FSM states: `IDLE`, `RMW_WRITE`.
- **Reset values:** state `IDLE`. `req_ready` 1. `resp_valid`, `resp_rdata`, `mem_err`, `dm_MemRead`, `dm_MemWrite`, `dm_addr` and `dm_write_data` are all 0.
- **Error check on accept:**
  - Misaligned: half with `addr[0]` set, or word with `addr[1:0]` nonzero.
  - Out of range: `addr[31:2] >= DEPTH_WORDS`.
  - On error: no `dm_MemRead` or `dm_MemWrite`. Next cycle `resp_valid=1`, `mem_err=1`, `resp_rdata=0`.
- **IDLE, load:**
  - `dm_MemRead=1` and `dm_addr={addr[31:2],2'b00}` combinationally.
  - `dm_read_data` is captured at the edge.
  - Byte lane is `addr[1:0]`, with lane 0 at bits 7:0. Half lane is `addr[1]`.
- **IDLE, word store:** `dm_MemWrite=1` and `dm_write_data=req_wdata` combinationally; the write commits at the edge.
- **IDLE, sub-word store:**
  - `dm_MemRead=1` in the accept cycle.
  - Registers: the merged word (old word with the target lane replaced by `req_wdata[7:0]` or `[15:0]`) and the address.
  - Then go to `RMW_WRITE`.
- **RMW_WRITE:**
  - `req_ready=0`.
  - `dm_MemWrite=1` with the registered address and merged data.
  - Then return to `IDLE`.
- **Outside these cases:** `dm_MemRead` and `dm_MemWrite` are 0. `req_valid` without `req_read` or `req_write` is accepted with no memory access and no response.
- **Reset during `RMW_WRITE`:** the write is abandoned (`dm_MemWrite` stays 0), state goes to `IDLE`, and no response is produced.

## Timing
- **Load accepted in cycle N:** `resp_valid` and data in N+1.
- **Word store accepted in N:** memory is updated at the end of N; `resp_valid` in N+1.
- **Sub-word store accepted in N:**
  - Read in N, write in N+1, `resp_valid` in N+2.
  - `req_ready` is low for all of N+1.
- **Ordering:** a load accepted in the cycle after a store returns the stored data, because the write commits before the combinational read.
- **Throughput:** one request per cycle, except one bubble per sub-word store.

## Configuration
- `MEM_SUBWORD_EN` defined:
  - Full behaviour as above: byte/half support, RMW state, extension logic.
- `MEM_SUBWORD_EN` undefined:
  - `req_size` and `req_unsigned` are ignored; every access is a word access.
  - No `RMW_WRITE` state, and `req_ready` is constantly 1.
  - Misaligned checks apply to word alignment only.

## Test plan
- **Word load:** mem[2]=0x11223344; lw 0x8 -> `resp_rdata=0x11223344` one cycle after accept, `mem_err=0`.
- **Byte loads:** mem[2]=0x11223384; lb 0x8 -> 0xFFFFFF84; lbu 0x8 -> 0x00000084; lh 0xA -> 0x00001122.
- **Byte store (RMW):** mem[2]=0x11223344; sb 0xAA to 0x9 -> `req_ready` low one cycle, then mem[2]=0x1122AA44; `resp_valid` two cycles after accept.
- **Store then load:** sw 0xDEADBEEF to 0x4, then lw 0x4 next cycle -> 0xDEADBEEF.
- **Errors:** lw 0x6, and sw to 0x100 with `DEPTH_WORDS`=64 -> `mem_err` pulse, `resp_rdata=0`, `dm_MemWrite` never asserted, memory unchanged.
- **Reset mid-RMW:** sh 0xBEEF to 0x2, assert `reset` in the `RMW_WRITE` cycle -> no `dm_MemWrite`, mem[0] unchanged, `req_ready=1` the next cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store front end between the EX/MEM pipeline register and a word-addressed data memory.
// Loads use little-endian lane selection with sign/zero extension. Sub-word stores become a
// two-cycle read-modify-write. Misaligned and out-of-range accesses are rejected with mem_err.
//
// Optional feature macro: MEM_SUBWORD_EN
//   defined   : byte/half loads and stores, RMW_WRITE state, extension logic.
//   undefined : every access is a word access, req_ready is constantly 1.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/read/write          request strobe and kind (write wins over read)
//   req_size, req_unsigned        00 byte, 01 half, 1x word; zero-extend loads when set
//   req_addr, req_wdata           byte address, store data (sub-word value in low bits)
//   req_ready                     request accepted when req_valid && req_ready
//   resp_valid, resp_rdata        one-cycle completion pulse, extended load data
//   mem_err                       pulses with resp_valid for a rejected access
//   dm_MemRead/MemWrite/addr/
//   dm_write_data, dm_read_data   data-memory interface (read data is combinational)
module mem_access_unit #(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        mem_err,
  output logic        dm_MemRead,
  output logic        dm_MemWrite,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_write_data,
  input  logic [31:0] dm_read_data
);

  logic        is_word, is_half, misaligned, out_of_range, acc_err;
  logic        accept, has_op, is_load, op_ok;
  logic [31:0] word_addr, load_data;

  assign word_addr    = {req_addr[31:2], 2'b00};
  assign out_of_range = ({2'b00, req_addr[31:2]} >= DEPTH_WORDS);
  assign misaligned   = is_word ? (req_addr[1:0] != 2'b00) : (is_half & req_addr[0]);
  assign acc_err      = misaligned | out_of_range;
  assign accept       = req_valid & req_ready & ~reset;
  assign has_op       = req_read | req_write;
  assign is_load      = req_read & ~req_write;
  assign op_ok        = accept & has_op & ~acc_err;

`ifdef MEM_SUBWORD_EN
  typedef enum logic [0:0] {StIdle, StRmwWrite} state_e;

  state_e      state_q;
  logic [31:0] rmw_addr_q, rmw_data_q, merged;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sub_store, rmw_active;

  assign is_word    = req_size[1];
  assign is_half    = (req_size == 2'b01);
  assign sub_store  = req_write & ~is_word;
  assign req_ready  = (state_q == StIdle);
  // Reset abandons a pending RMW write.
  assign rmw_active = (state_q == StRmwWrite) & ~reset;
  assign byte_sel   = dm_read_data[{req_addr[1:0], 3'b000} +: 8];
  assign half_sel   = dm_read_data[{req_addr[1], 4'b0000} +: 16];

  always_comb begin
    if (is_word)      load_data = dm_read_data;
    else if (is_half) load_data = {{16{half_sel[15] & ~req_unsigned}}, half_sel};
    else              load_data = {{24{byte_sel[7] & ~req_unsigned}}, byte_sel};
  end

  // Old word with the target lane replaced by the store value.
  always_comb begin
    merged = dm_read_data;
    if (is_half) merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
    else         merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
  end
`else
  logic unused_subword;
  assign unused_subword = ^{req_size, req_unsigned};
  assign is_word        = 1'b1;
  assign is_half        = 1'b0;
  assign req_ready      = 1'b1;
  assign load_data      = dm_read_data;
`endif

  always_comb begin
    dm_MemRead    = 1'b0;
    dm_MemWrite   = 1'b0;
    dm_addr       = '0;
    dm_write_data = '0;
`ifdef MEM_SUBWORD_EN
    if (rmw_active) begin
      dm_MemWrite   = 1'b1;
      dm_addr       = rmw_addr_q;
      dm_write_data = rmw_data_q;
    end else
`endif
    if (op_ok) begin
      dm_addr = word_addr;
      if (req_write && is_word) begin
        dm_MemWrite   = 1'b1;
        dm_write_data = req_wdata;
      end else begin
        // Loads, and the read half of a sub-word store.
        dm_MemRead = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_err    <= 1'b0;
`ifdef MEM_SUBWORD_EN
      state_q    <= StIdle;
      rmw_addr_q <= '0;
      rmw_data_q <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_err    <= 1'b0;
`ifdef MEM_SUBWORD_EN
      if (state_q == StRmwWrite) begin
        state_q    <= StIdle;
        resp_valid <= 1'b1;
      end else if (op_ok && sub_store) begin
        state_q    <= StRmwWrite;
        rmw_addr_q <= word_addr;
        rmw_data_q <= merged;
      end else
`endif
      if (accept && has_op) begin
        resp_valid <= 1'b1;
        mem_err    <= acc_err;
        if (op_ok && is_load) resp_rdata <= load_data;
      end
    end
  end

endmodule
